// File: rtl/i2s_pkg.sv
// Shared I2S constants for the transmitter and receiver: frame geometry,
// idle bit index and word-select encoding.
package i2s_pkg;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BIT_IDX_W  = 6;

    // Idle bit index: two falls from idle reach the first load (62 -> 63 -> 0)
    localparam logic [BIT_IDX_W-1:0] B_IDLE = BIT_IDX_W'(FRAME_BITS - 2);

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock divider: registered sck plus single-cycle rise/fall strobes
// marking the clk cycle whose edge toggles sck.
module i2s_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          tc;

    assign tc = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tc) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck  = sck_q;
    assign rise = en && tc && !sck_q;
    assign fall = en && tc &&  sck_q;
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry sample-pair holding register feeding a
// 64-bit frame shifter; sd/ws update on SCK falls, all outputs registered.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = i2s_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              sck,
    output logic              ws,
    output logic              sd,
    output logic              frame_start,
    output logic              underrun
);
    localparam int FB = 2 * SLOT_W;
    localparam int BW = $clog2(FB);
    localparam logic [BW-1:0] B_RST = BW'(FB - 2);

    logic              rise, fall, load, accept;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [FB-1:0]     sr_q, sr_d, frame_word;
    logic [SLOT_W-1:0] l_slot, r_slot;
    logic [BW-1:0]     b_q, b_d, b_ahead;
    logic              ws_q, ws_d, sd_q, sd_d, fs_q, fs_d, ur_q, ur_d;

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .sck  (sck),
        .rise (rise),
        .fall (fall)
    );

    // Samples are MSB-aligned in their slot; the low bits are pad zeros
    assign l_slot     = SLOT_W'(hold_l_q) << (SLOT_W - DATA_W);
    assign r_slot     = SLOT_W'(hold_r_q) << (SLOT_W - DATA_W);
    assign frame_word = {l_slot, r_slot};

    assign accept  = s_valid && !hold_full_q;
    assign load    = fall && (b_q == {BW{1'b1}});
    assign b_ahead = b_q + BW'(2);

    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sr_d        = sr_q;
        b_d         = b_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_left;
            hold_r_d    = s_right;
        end

        if (!en) begin
            sr_d = '0;
            b_d  = B_RST;
            ws_d = WS_RIGHT;
            sd_d = 1'b0;
        end else if (fall) begin
            b_d  = b_q + 1'b1;
            // ws carries the channel of the bit after the one now going out
            ws_d = b_ahead[BW-1] ? WS_RIGHT : WS_LEFT;
            if (load) begin
                fs_d = 1'b1;
                ur_d = !hold_full_q;
                if (hold_full_q) begin
                    hold_full_d = 1'b0;
                    sd_d        = frame_word[FB-1];
                    sr_d        = frame_word << 1;
                end else begin
                    sd_d = 1'b0;
                    sr_d = '0;
                end
            end else begin
                sd_d = sr_q[FB-1];
                sr_d = sr_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sr_q        <= '0;
            b_q         <= B_RST;
            ws_q        <= WS_RIGHT;
            sd_q        <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sr_q        <= sr_d;
            b_q         <= b_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
        end
    end

    assign s_ready     = !hold_full_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

    logic unused_rise;
    assign unused_rise = rise;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at default parameters: vector table for the first
// frame, plus starvation, loopback, accept-on-load, en drop and async reset.
module tb_i2s_tx;
    logic        clk, rst_n, en, s_valid, s_ready;
    logic [23:0] s_left, s_right;
    logic        sck, ws, sd, frame_start, underrun;

    int tests = 0;
    int fails = 0;

    i2s_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .sck        (sck),
        .ws         (ws),
        .sd         (sd),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // k = clk edges since en rose; exp = {sck, ws, sd, frame_start, underrun}
    typedef struct {
        int         k;
        logic [4:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    logic [23:0] pl[16], pr[16];
    logic [63:0] rxf;

    initial begin
        int idx, urc, urk, ones, pi, ri, rxb;
        logic act_rx, fire, sck_p;

        tbl[0]  = '{1,   5'b01000};
        tbl[1]  = '{2,   5'b11000};
        tbl[2]  = '{4,   5'b00000};  // pre-roll b=63
        tbl[3]  = '{6,   5'b10000};
        tbl[4]  = '{8,   5'b00110};  // load, left MSB
        tbl[5]  = '{9,   5'b00100};
        tbl[6]  = '{12,  5'b00000};
        tbl[7]  = '{14,  5'b10000};
        tbl[8]  = '{16,  5'b00100};
        tbl[9]  = '{100, 5'b00100};  // left LSB
        tbl[10] = '{104, 5'b00000};  // pad
        tbl[11] = '{128, 5'b00000};
        tbl[12] = '{132, 5'b01000};  // ws leads right MSB
        tbl[13] = '{136, 5'b01000};
        tbl[14] = '{144, 5'b01100};
        tbl[15] = '{220, 5'b01100};
        tbl[16] = '{256, 5'b01000};
        tbl[17] = '{260, 5'b00000};
        tbl[18] = '{264, 5'b00011};  // empty-hold load
        tbl[19] = '{265, 5'b00000};

        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
        #12;
        chk("reset_state", {sck, ws, sd, frame_start, underrun, s_ready}, 6'b010001);
        rst_n = 1'b1;
        tick();

        // Single pair, pushed before en
        s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h3C3C3C;
        tick();
        s_valid = 1'b0;
        chk("hold_full", s_ready, 1'b0);
        en = 1'b1;
        idx = 0;
        for (int k = 1; k <= 265; k++) begin
            tick();
            if (idx < NV && tbl[idx].k == k) begin
                chk($sformatf("vec%0d_k%0d", idx, k), {sck, ws, sd, frame_start, underrun}, tbl[idx].exp);
                idx++;
            end
        end

        // Starvation: next zero frame, underrun again 256 clk later
        urc = 0; urk = 0; ones = 0;
        for (int k = 266; k <= 520; k++) begin
            tick();
            if (underrun) begin urc++; urk = k; end
            if (sd) ones++;
        end
        chk("starve_ur_count", urc, 1);
        chk("starve_ur_at", urk, 520);
        chk("starve_sd_zero", ones, 0);

        en = 1'b0;
        tick();
        chk("idle_after_en0", {sck, ws, sd}, 3'b010);

        // Loopback through a bench-side receiver keyed on frame_start/sck rise
        for (int i = 0; i < 16; i++) begin
            pl[i] = 24'($urandom);
            pr[i] = 24'($urandom);
        end
        pi = 0; ri = 0; urc = 0; rxb = 0; act_rx = 1'b0; sck_p = 1'b0;
        s_valid = 1'b1; s_left = pl[0]; s_right = pr[0];
        fire = s_ready;
        en = 1'b1;
        for (int c = 0; c < 6000 && ri < 16; c++) begin
            tick();
            if (fire) pi++;
            if (underrun) urc++;
            if (frame_start) begin
                act_rx = 1'b1;
                rxb = 0;
            end else if (act_rx && sck && !sck_p) begin
                rxf[63-rxb] = sd;
                rxb++;
                if (rxb == 64) begin
                    chk($sformatf("loop_pair%0d", ri), {rxf[63:40], rxf[31:8]}, {pl[ri], pr[ri]});
                    ri++;
                    act_rx = 1'b0;
                end
            end
            sck_p = sck;
            if (pi < 16) begin
                s_valid = 1'b1; s_left = pl[pi]; s_right = pr[pi];
            end else begin
                s_valid = 1'b0;
            end
            fire = s_valid && s_ready;
        end
        s_valid = 1'b0;
        chk("loop_frames", ri, 16);
        chk("loop_underruns", urc, 0);

        en = 1'b0;
        tick();
        chk("ready_empty", s_ready, 1'b1);

        // Accept on the load cycle with hold empty
        en = 1'b1;
        ones = 0;
        for (int k = 1; k <= 356; k++) begin
            tick();
            if (k == 7) begin
                s_valid = 1'b1; s_left = 24'h800001; s_right = 24'h000001;
            end
            if (k == 8) begin
                chk("acc_load_k8", {sd, frame_start, underrun, s_ready}, 4'b0110);
                s_valid = 1'b0;
            end
            if (k > 8 && k < 264 && sd) ones++;
            if (k == 264) chk("acc_next_frame", {sd, frame_start, underrun}, 3'b110);
            if (k == 356) chk("acc_left_lsb", sd, 1'b1);
        end
        chk("acc_zero_frame", ones, 0);

        // en drop mid-frame with a pair held
        en = 1'b0;
        tick();
        s_valid = 1'b1; s_left = 24'hFEDCBA; s_right = 24'h123456;
        tick();
        s_valid = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            tick();
            if (k == 8) begin
                chk("p_load", {sd, frame_start, underrun}, 3'b110);
                s_valid = 1'b1; s_left = 24'hC00000; s_right = 24'h000003;
            end
            if (k == 9) s_valid = 1'b0;
            if (k == 170) chk("pre_drop_b40", {sck, ws}, 2'b11);
        end
        en = 1'b0;
        tick();
        chk("en_drop", {sck, ws, sd, frame_start, underrun, s_ready}, 6'b010000);
        repeat (3) tick();
        en = 1'b1;
        for (int k = 1; k <= 102; k++) begin
            tick();
            if (k == 4)  chk("restart_preroll", {ws, sd, frame_start}, 3'b000);
            if (k == 8)  chk("restart_load", {sd, frame_start, underrun}, 3'b110);
            if (k == 12) chk("restart_b1", sd, 1'b1);
            if (k == 16) chk("restart_b2", sd, 1'b0);
            if (k == 20) begin
                s_valid = 1'b1; s_left = 24'h111111; s_right = 24'h222222;
            end
            if (k == 21) s_valid = 1'b0;
        end
        chk("pre_reset", {sck, ws, s_ready}, 3'b100);

        // Async reset away from the clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {sck, ws, sd, frame_start, underrun, s_ready}, 6'b010001);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
